// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: sample format, layer-1 map geometry, signed max helper.
package cnn_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FRAC_W  = 12;
  localparam int unsigned MAP_W   = 88;
  localparam int unsigned MAP_H   = 88;
  localparam int unsigned OUT_W   = MAP_W / 2;
  localparam int unsigned NUM_OUT = (MAP_W / 2) * (MAP_H / 2);

  typedef logic signed [DATA_W-1:0] sample_t;

  // Field view of a Q4.12 sample, for debug and downstream formatting.
  typedef struct packed {
    logic signed [DATA_W-FRAC_W-1:0] int_part;
    logic        [FRAC_W-1:0]        frac_part;
  } q_sample_t;

  function automatic sample_t smax(sample_t a, sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line of partial maxima: one write port, one asynchronous read port.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int unsigned DEPTH = OUT_W,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/m_pool_1_5.sv
// 2x2/stride-2 signed max-pool on the raster layer-1 conv stream (88x88 -> 44x44).
// Build option: define M_POOL_RELU_EN to clamp negative pooled results to zero.
module m_pool_1_5
  import cnn_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] map_in,
  input  logic        save_in,
  output logic [15:0] map_out,
  output logic        save,
  output logic        ready
);

  localparam int unsigned COL_W  = $clog2(MAP_W);
  localparam int unsigned ROW_W  = $clog2(MAP_H);
  localparam int unsigned ADDR_W = $clog2(OUT_W);
  localparam int unsigned CNT_W  = $clog2(NUM_OUT + 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  sample_t           h_q, h_d;
  sample_t           map_out_q, map_out_d;
  logic              save_q, save_d;
  logic              ready_q, ready_d;

  logic              accept_c;
  logic              lb_we_c;
  logic [ADDR_W-1:0] lb_addr_c;
  logic [DATA_W-1:0] lb_rdata_c;
  sample_t           hmax_c;
  sample_t           vmax_c;
  sample_t           pool_c;

  pool_line_buf #(
    .DEPTH (OUT_W),
    .AW    (ADDR_W)
  ) u_line_buf (
    .clk_in  (clk_in),
    .we_i    (lb_we_c),
    .waddr_i (lb_addr_c),
    .wdata_i (hmax_c),
    .raddr_i (lb_addr_c),
    .rdata_o (lb_rdata_c)
  );

  // Horizontal pair max, then vertical max against the stored even-row result.
  always_comb begin
    accept_c  = start & save_in & ready_q;
    lb_addr_c = ADDR_W'(col_q >> 1);
    hmax_c    = smax(h_q, sample_t'(map_in));
    vmax_c    = smax(sample_t'(lb_rdata_c), hmax_c);
`ifdef M_POOL_RELU_EN
    pool_c    = vmax_c[DATA_W-1] ? '0 : vmax_c;
`else
    pool_c    = vmax_c;
`endif
    lb_we_c   = accept_c & col_q[0] & ~row_q[0];
  end

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    out_cnt_d = out_cnt_q;
    h_d       = h_q;
    map_out_d = map_out_q;
    save_d    = 1'b0;
    ready_d   = (out_cnt_q != CNT_W'(NUM_OUT));

    if (accept_c) begin
      if (!col_q[0]) begin
        h_d = sample_t'(map_in);
      end else if (row_q[0]) begin
        map_out_d = pool_c;
        save_d    = 1'b1;
      end

      if (col_q == COL_W'(MAP_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(MAP_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (save_d && (out_cnt_q != CNT_W'(NUM_OUT))) out_cnt_d = out_cnt_q + CNT_W'(1);

    // Frame disable clears everything except the buffer contents.
    if (!start) begin
      col_d     = '0;
      row_d     = '0;
      out_cnt_d = '0;
      h_d       = '0;
      map_out_d = '0;
      save_d    = 1'b0;
      ready_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      h_q       <= '0;
      map_out_q <= '0;
      save_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      out_cnt_q <= out_cnt_d;
      h_q       <= h_d;
      map_out_q <= map_out_d;
      save_q    <= save_d;
      ready_q   <= ready_d;
    end
  end

  assign map_out = map_out_q;
  assign save    = save_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_m_pool_1_5.sv
// Directed bench for m_pool_1_5: ramp/random frames, gaps, abort, async reset, overrun.
module tb_m_pool_1_5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] map_in;
  logic        save_in;
  logic [15:0] map_out;
  logic        save;
  logic        ready;

  int          checks = 0;
  int          errors = 0;
  int          fr [88][88];
  logic [15:0] exp_q [$];
  logic        drv_oo = 1'b0;
  logic        oo_at_edge = 1'b0;
  logic        mon_en = 1'b0;
  int          model_cnt = 0;
  logic [15:0] last_exp = '0;

  always #5 clk = ~clk;

  m_pool_1_5 dut (
    .clk_in  (clk),
    .rst_n   (rst_n),
    .start   (start),
    .map_in  (map_in),
    .save_in (save_in),
    .map_out (map_out),
    .save    (save),
    .ready   (ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pool4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
`ifdef M_POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return 16'(m);
  endfunction

  // save must follow exactly the edge that captured an odd/odd sample.
  always @(posedge clk) oo_at_edge <= drv_oo;

  always @(negedge clk) begin
    if (mon_en) begin
      check("save", 32'(save), 32'(oo_at_edge));
      if (save && oo_at_edge) begin
        if (exp_q.size() == 0) check("exp_avail", 32'(exp_q.size()), 32'(1));
        else check("map_out", 32'(map_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_frame(input int i0, input int n, input int gmax, input bit ramp);
    for (int i = i0; i < i0 + n; i++) begin
      int idx;
      int r;
      int c;
      int v;
      bit oo;
      logic [15:0] e;
      idx = i % 7744;
      r   = idx / 88;
      c   = idx % 88;
      v   = ramp ? idx : fr[r][c];
      oo  = (r % 2 == 1) && (c % 2 == 1) && (model_cnt < 1936);
      if (oo) begin
        e = ramp ? 16'(r * 88 + c)
                 : pool4(fr[r-1][c-1], fr[r-1][c], fr[r][c-1], fr[r][c]);
        exp_q.push_back(e);
        last_exp = e;
        model_cnt++;
      end
      map_in  = 16'(v);
      save_in = 1'b1;
      drv_oo  = oo;
      @(posedge clk);
      #1;
      save_in = 1'b0;
      drv_oo  = 1'b0;
      if (oo && model_cnt == 1936) begin
        check("ready_last", 32'(ready), 32'(1));
        @(posedge clk);
        #1;
        check("ready_fall", 32'(ready), 32'(0));
      end
      if (gmax > 0) begin
        repeat ($urandom_range(0, gmax)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic restart();
    start = 1'b0;
    @(posedge clk);
    #1;
    check("clr_ready", 32'(ready), 32'(1));
    check("clr_save", 32'(save), 32'(0));
    check("clr_map_out", 32'(map_out), 32'(0));
    check("clr_queue", 32'(exp_q.size()), 32'(0));
    start     = 1'b1;
    model_cnt = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    save_in = 1'b0;
    map_in  = '0;

    // T1 reset values, then idle with no input
    #12;
    check("rst_map_out", 32'(map_out), 32'(0));
    check("rst_save", 32'(save), 32'(0));
    check("rst_ready", 32'(ready), 32'(1));
    #10;
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("idle_ready", 32'(ready), 32'(1));

    // T2 ramp frame, no gaps
    send_frame(0, 7744, 0, 1'b1);
    check("t2_count", 32'(model_cnt), 32'(1936));

    // T3 random signed frame with a hand-built negative block at the origin
    restart();
    for (int r = 0; r < 88; r++)
      for (int c = 0; c < 88; c++)
        fr[r][c] = int'($urandom_range(0, 65535)) - 32768;
    fr[0][0] = -5;
    fr[0][1] = -3;
    fr[1][0] = -7;
    fr[1][1] = -4;
    send_frame(0, 90, 0, 1'b0);
`ifdef M_POOL_RELU_EN
    check("signed_blk", 32'(map_out), 32'(16'h0000));
`else
    check("signed_blk", 32'(map_out), 32'(16'hFFFD));
`endif
    send_frame(90, 7654, 0, 1'b0);

    // T4 ramp with random idle gaps
    restart();
    send_frame(0, 7744, 5, 1'b1);

    // T5 abort by start drop, then full frame
    restart();
    send_frame(0, 3000, 0, 1'b1);
    restart();
    send_frame(0, 7744, 1, 1'b1);
    check("t5_ready_end", 32'(ready), 32'(0));

    // T5 abort by async reset mid-frame, then full frame
    restart();
    send_frame(0, 2500, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_map_out", 32'(map_out), 32'(0));
    check("arst_save", 32'(save), 32'(0));
    check("arst_ready", 32'(ready), 32'(1));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    model_cnt = 0;
    send_frame(0, 7744, 0, 1'b1);
    check("t5b_ready_end", 32'(ready), 32'(0));

    // T6 overrun after frame complete
    send_frame(0, 200, 0, 1'b1);
    check("ovr_map_out", 32'(map_out), 32'(last_exp));
    check("ovr_ready", 32'(ready), 32'(0));
    check("ovr_queue", 32'(exp_q.size()), 32'(0));

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
